demux_stream_1xn: RTL and testbench

Registered, parametrised 1-to-N stream demultiplexer with valid/ready flow control. It generalises the combinational binary demux tree to multi-bit data, an arbitrary (non-power-of-two) channel count, per-channel backpressure and a broadcast mode. It sits between a single producer stream and N consumer channels in the IO test designs, where a one-cycle registered hop is needed to break timing.

---
 rtl/demux_stream_pkg.sv | 24 ++
 rtl/demux_stream_1xn_if.sv | 37 +++
 rtl/demux_onehot_dec.sv | 28 ++
 rtl/demux_stream_1xn.sv | 80 ++++++++
 tb/tb_demux_stream_1xn.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/demux_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_stream_pkg                                          |
// | Brief    : Shared constants and helpers for the 1-to-N stream demux. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package demux_stream_pkg;

    localparam int ERR_W_DEFAULT = 8;
    localparam int MAX_N_OUT     = 512;

    // Out-of-range selects produce an empty mask so callers can treat them as drops.
    function automatic logic [MAX_N_OUT-1:0] onehot_mask(input int unsigned sel,
                                                         input int unsigned n);
        logic [MAX_N_OUT-1:0] m;
        m = '0;
        if ((sel < n) && (sel < MAX_N_OUT)) begin
            m = MAX_N_OUT'(1) << sel;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_1xn_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_stream_1xn_if                                       |
// | Brief    : Producer and consumer-side stream bundle for the demux.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface demux_stream_1xn_if
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 6,
    parameter int ERR_W  = ERR_W_DEFAULT
);
    localparam int SEL_W = $clog2(N_OUT);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [ERR_W-1:0]        err_cnt;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/demux_onehot_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_onehot_dec                                          |
// | Brief    : Select to one-hot decoder with an in-range flag.          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module demux_onehot_dec
    import demux_stream_pkg::*;
#(
    parameter int N_OUT = 6,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  wire logic [SEL_W-1:0] sel,
    output logic      [N_OUT-1:0] onehot,
    output logic                  in_range
);

    // N_OUT need not be a power of two, so the top codes of sel are illegal.
    assign in_range = (32'(sel) < N_OUT);

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_bit
            assign onehot[k] = (sel == SEL_W'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demux_stream_1xn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_stream_1xn                                          |
// | Brief    : Registered 1-to-N valid/ready demux with broadcast.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module demux_stream_1xn
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 6,
    parameter int ERR_W  = ERR_W_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    demux_stream_1xn_if.slave bus
);

    localparam int SEL_W = $clog2(N_OUT);

    logic [DATA_W-1:0] r_data;
    logic [N_OUT-1:0]  r_pend;
    logic [ERR_W-1:0]  r_err_cnt;

    logic [N_OUT-1:0]  w_resid;
    logic [N_OUT-1:0]  w_onehot;
    logic              w_in_range;
    logic              w_in_ready;
    logic              w_accept;

    demux_onehot_dec #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel      (bus.in_sel),
        .onehot   (w_onehot),
        .in_range (w_in_range)
    );

    // Ready looks through the current cycle's drain so a fully consumed
    // beat can be replaced without a bubble.
    assign w_resid    = r_pend & ~bus.out_ready;
    assign w_in_ready = (w_resid == '0);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_pend    <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            if (bus.in_bcast) begin
                r_data <= bus.in_data;
                r_pend <= '1;
            end else if (w_in_range) begin
                r_data <= bus.in_data;
                r_pend <= w_onehot;
            end else begin
                r_pend <= '0;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end
        end else begin
            r_pend <= w_resid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_pend;
    assign bus.err_cnt   = r_err_cnt;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_lane
            assign bus.out_data[k*DATA_W +: DATA_W] = r_pend[k] ? r_data : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1xn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_demux_stream_1xn                                       |
// | Brief    : Directed self-checking bench for demux_stream_1xn.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_demux_stream_1xn;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    demux_stream_1xn_if #(.DATA_W(8), .N_OUT(6), .ERR_W(8)) bus ();

    demux_stream_1xn #(
        .DATA_W (8),
        .N_OUT  (6),
        .ERR_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [47:0] exp_lane_b2b [3];
        exp_lane_b2b[0] = 48'h0000_0000_0011;
        exp_lane_b2b[1] = 48'h0000_0000_2200;
        exp_lane_b2b[2] = 48'h0000_0033_0000;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 3'd0;
        bus.in_bcast  = 1'b0;
        bus.out_ready = 6'b000000;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_out_data", 64'(bus.out_data), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("rst_err_cnt", 64'(bus.err_cnt), 64'h0);
        rst_n = 1'b1;

        // Single unicast beat to channel 3
        bus.out_ready = 6'b111111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd3;
        bus.in_data   = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        check("uni_valid", 64'(bus.out_valid), 64'h08);
        check("uni_data", 64'(bus.out_data), 64'h0000_A500_0000);
        check("uni_in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        check("uni_drained", 64'(bus.out_valid), 64'h0);
        check("uni_data_zero", 64'(bus.out_data), 64'h0);

        // Back-to-back beats to channels 0,1,2
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 3'(i);
            bus.in_data  = 8'(8'h11 * (i + 1));
            #1;
            check("b2b_in_ready", 64'(bus.in_ready), 64'h1);
            tick();
            check("b2b_valid", 64'(bus.out_valid), 64'(6'b000001 << i));
            check("b2b_data", 64'(bus.out_data), 64'(exp_lane_b2b[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        check("b2b_drained", 64'(bus.out_valid), 64'h0);

        // Broadcast with staggered per-channel drain
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b1;
        bus.in_data   = 8'h3C;
        bus.out_ready = 6'b000101;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        check("bc_valid_all", 64'(bus.out_valid), 64'h3F);
        check("bc_data_all", 64'(bus.out_data), 64'h3C3C_3C3C_3C3C);
        check("bc_in_ready_lo", 64'(bus.in_ready), 64'h0);
        tick();
        check("bc_valid_part", 64'(bus.out_valid), 64'h3A);
        check("bc_data_part", 64'(bus.out_data), 64'h3C3C_3C00_3C00);
        bus.out_ready = 6'b111010;
        #1;
        check("bc_in_ready_hi", 64'(bus.in_ready), 64'h1);
        tick();
        check("bc_done", 64'(bus.out_valid), 64'h0);
        check("bc_data_done", 64'(bus.out_data), 64'h0);

        // Illegal select: dropped, counter saturates at 0xFF
        bus.out_ready = 6'b111111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd7;
        bus.in_data   = 8'hEE;
        for (int i = 0; i < 300; i++) begin
            #1;
            check("drop_in_ready", 64'(bus.in_ready), 64'h1);
            tick();
            check("drop_no_valid", 64'(bus.out_valid), 64'h0);
            check("drop_err_cnt", 64'(bus.err_cnt), 64'((i + 1 > 255) ? 255 : i + 1));
        end
        bus.in_valid = 1'b0;
        tick();
        check("drop_err_sat", 64'(bus.err_cnt), 64'hFF);

        // Backpressure on channel 4, next beat waiting
        bus.out_ready = 6'b101111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd4;
        bus.in_data   = 8'h5A;
        tick();
        bus.in_sel  = 3'd1;
        bus.in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'h10);
            check("bp_data", 64'(bus.out_data), 64'h005A_0000_0000);
            check("bp_in_ready", 64'(bus.in_ready), 64'h0);
            tick();
        end
        bus.out_ready = 6'b111111;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_valid", 64'(bus.out_valid), 64'h02);
        check("bp_next_data", 64'(bus.out_data), 64'h0000_0000_7700);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'h0);

        // Reset during a partially drained broadcast
        bus.out_ready = 6'b000101;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b1;
        bus.in_data   = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        tick();
        check("mid_partial", 64'(bus.out_valid), 64'h3A);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        check("mid_rst_data", 64'(bus.out_data), 64'h0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("mid_rst_err", 64'(bus.err_cnt), 64'h0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
